sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, giving the data word width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 16, giving the number of entries; it must be a power of 2 and at least 4.
REQ-003 The module SHALL have parameter AF_LVL, default DEPTH-2, setting the almost_full threshold.
REQ-004 The module SHALL have parameter AE_LVL, default 2, setting the almost_empty threshold.
REQ-005 Clock clkrstn; reset clkrstn, asynchronous, active-high. Both SHALL be carried on interface port clkrstn as clkrstn.clk and clkrstn.rst.
REQ-006 The module SHALL have these ports:
- clkrstn.clk  in  1  clock, rising edge
- clkrstn.rst  in  1  asynchronous active-high reset
- wr_en  in  1  write request
- wr_data  in  DATA_W  write word
- rd_en  in  1  read request
- clr_err  in  1  clears the sticky error flags
- rd_data  out  DATA_W  read word
- rd_valid  out  1  rd_data is valid this cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LVL
- almost_empty  out  1  count <= AE_LVL
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: write rejected
- underflow  out  1  sticky: read rejected

Function
REQ-007 A write SHALL be accepted on a rising edge when wr_en=1 and (full=0 or a read is accepted in the same cycle); the accepted word is stored at wr_ptr and wr_ptr increments.
REQ-008 A read SHALL be accepted on a rising edge when rd_en=1 and empty=0; the word at rd_ptr is registered into rd_data, rd_ptr increments, and rd_valid=1 in the following cycle.
REQ-009 Read latency SHALL be exactly 1 cycle; rd_valid SHALL be 0 in any cycle following no accepted read, and rd_data SHALL hold its last value.
REQ-010 The FIFO SHALL NOT fall through: a write and a read requested on an empty FIFO in the same cycle SHALL accept the write only, reject the read, and set underflow.
REQ-011 A simultaneous write and read on a full FIFO SHALL accept both; count stays DEPTH and the written word is stored in the slot just freed.
REQ-012 Count SHALL update as follows: +1 on write only, -1 on read only, and unchanged on both or neither.
REQ-013 wr_ptr and rd_ptr SHALL be $clog2(DEPTH)+1 bits wide, including an MSB wrap bit; they SHALL wrap modulo 2*DEPTH, with no discontinuity when the address wraps from DEPTH-1 to 0.
REQ-014 full, empty, almost_full, almost_empty and count SHALL be registered outputs reflecting post-edge occupancy; no combinational path SHALL exist from wr_en or rd_en to any output.
REQ-015 wr_en=1 with a write not accepted SHALL set overflow, and that write SHALL be dropped without changing state.
REQ-016 rd_en=1 with a read not accepted SHALL set underflow, leaving rd_valid=0 and rd_data unchanged.
REQ-017 overflow and underflow SHALL remain set until clr_err=1 at a rising edge; a clear and a new error in the same cycle SHALL leave the flag set.

Reset
REQ-018 Asserting clkrstn.rst SHALL immediately force the following, independent of the clock:
- wr_ptr=0, rd_ptr=0, count=0
- empty=1, full=0, almost_empty=1, almost_full=0
- rd_valid=0, rd_data=0
- overflow=0, underflow=0
REQ-019 Storage contents SHALL NOT be reset. Reset asserted mid-operation SHALL discard all stored words and any in-flight read, and the first write after release SHALL land at address 0.
REQ-020 Reset release SHALL be synchronous to clkrstn.clk in the environment; accesses SHALL be accepted from the first rising edge with rst=0.

Structure
REQ-021 Package fifo_pkg SHALL hold the default DATA_W and DEPTH constants and a typedef for the data word shared with the testbench transaction class.
REQ-022 Storage SHALL be a sub-module fifo_mem: a simple dual-port array with 1 write port and 1 registered read port and no reset. Pointers, count, flags and error logic SHALL stay in sync_fifo.

Verification
REQ-023 Reset then write 0x01..0x10 (16 writes) -> full=1 and count=16 after the 16th edge, almost_full=1 from count=14, overflow=0.
REQ-024 With the FIFO full, write 0xAA -> overflow=1, count=16, and 16 reads return 0x01..0x10 in order, each with rd_valid=1 one cycle after its rd_en.
REQ-025 Read on empty -> underflow=1 and rd_valid=0; one clr_err pulse -> underflow=0 on the next edge.
REQ-026 Write 12 words, read 12, repeat 3 times -> pointers wrap past 15; all 36 words return in order, with empty=1 at the end.
REQ-027 Simultaneous wr_en and rd_en at count=0, 5 and 16 -> count goes 1, 5 and 16 respectively, with underflow set only in the count=0 case.
REQ-028 Assert rst mid-burst with count=7 -> all outputs reach reset values without a clock edge; a subsequent write and read of 0x5C returns 0x5C.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and data-word type for the synchronous FIFO and its bench.
package fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    typedef logic [DATA_W_DEF-1:0] data_t;

endpackage

// File: rtl/clkrstn_if.sv
// Clock and asynchronous active-high reset bundle shared by the FIFO blocks.
interface clkrstn_if;

    logic clk;
    logic rst;

    modport sink (input clk, input rst);

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the array is deliberately left unreset so it maps onto plain RAM;
    // only the read register, which is visible at the port, is reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Holds its value when no read is accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO: pointers, occupancy, registered flags and sticky errors
// around the fifo_mem storage block.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    clkrstn_if.sink                    clkrstn,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    input  logic                       clr_err,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q, af_q, ae_q;
    logic          rd_valid_q, ovf_q, ovf_d, unf_q, unf_d;
    logic          wr_acc, rd_acc;

    // NOTE: combinational logic uses blocking assignments with every output
    // given a value on every path, so no latches are inferred.
    always_comb begin
        // A read never falls through: the read sees only pre-edge occupancy.
        rd_acc   = rd_en && !empty_q;
        wr_acc   = wr_en && (!full_q || rd_acc);
        wr_ptr_d = wr_acc ? wr_ptr_q + CW'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + CW'(1) : rd_ptr_q;
        count_d  = wr_ptr_d - rd_ptr_d;
        ovf_d    = (ovf_q && !clr_err) || (wr_en && !wr_acc);
        unf_d    = (unf_q && !clr_err) || (rd_en && !rd_acc);
    end

    always_ff @(posedge clkrstn.clk or posedge clkrstn.rst) begin
        if (clkrstn.rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == DEPTH_C);
            empty_q    <= (count_d == '0);
            af_q       <= (count_d >= AF_C);
            ae_q       <= (count_d <= AE_C);
            rd_valid_q <= rd_acc;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i   (clkrstn.clk),
        .rst_i   (clkrstn.rst),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_data),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_data)
    );

    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;
    import fifo_pkg::*;

    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    clkrstn_if clkrstn ();

    logic       wr_en, rd_en, clr_err;
    data_t      wr_data, rd_data;
    logic       rd_valid, full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a queue plus the externally visible registers.
    data_t q[$];
    data_t m_data  = '0;
    bit    m_valid = 1'b0;
    bit    m_ovf   = 1'b0;
    bit    m_unf   = 1'b0;

    sync_fifo #(
        .DATA_W (8),
        .DEPTH  (DEPTH),
        .AF_LVL (AF),
        .AE_LVL (AE)
    ) dut (
        .clkrstn      (clkrstn),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .clr_err      (clr_err),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clkrstn.clk = 1'b0;
    always #5 clkrstn.clk = ~clkrstn.clk;

    // Field order: count, full, empty, almost_full, almost_empty, ovf, unf, rd_valid, rd_data.
    function automatic logic [19:0] observed();
        return {count, full, empty, almost_full, almost_empty,
                overflow, underflow, rd_valid, rd_data};
    endfunction

    function automatic logic [19:0] expected();
        int n;
        n = q.size();
        return {5'(n), n == DEPTH, n == 0, n >= AF, n <= AE,
                m_ovf, m_unf, m_valid, m_data};
    endfunction

    task automatic model_reset();
        q.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // One clock cycle of stimulus; the model advances with the edge, and the
    // task returns on the following falling edge, ready for sampling.
    task automatic step(input bit wr, input data_t d, input bit rd, input bit clr);
        bit ra, wa;
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        clr_err = clr;
        @(posedge clkrstn.clk);
        ra = rd && (q.size() > 0);
        wa = wr && ((q.size() < DEPTH) || ra);
        m_valid = ra;
        if (ra) m_data = q.pop_front();
        if (wa) q.push_back(d);
        m_ovf = (m_ovf && !clr) || (wr && !wa);
        m_unf = (m_unf && !clr) || (rd && !ra);
        @(negedge clkrstn.clk);
    endtask

    task automatic test_reset();
        clkrstn.rst = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
        model_reset();
        #2;
        checks++;
        if (observed() !== expected()) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", observed(), expected());
        end
        @(negedge clkrstn.clk);
        clkrstn.rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, data_t'(i), 1'b0, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL fill write %0d: got %h expected %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_overflow_drain();
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        checks++;
        if (observed() !== expected()) begin
            errors++;
            $display("FAIL overflow_on_full: got %h expected %h", observed(), expected());
        end
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL drain read %0d: got %h expected %h", i, observed(), expected());
            end
        end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (observed() !== expected()) begin
            errors++;
            $display("FAIL idle_hold: got %h expected %h", observed(), expected());
        end
        step(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_underflow();
        step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (observed() !== expected()) begin
            errors++;
            $display("FAIL underflow_on_empty: got %h expected %h", observed(), expected());
        end
        step(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (observed() !== expected()) begin
            errors++;
            $display("FAIL clr_underflow: got %h expected %h", observed(), expected());
        end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 12; i++) begin
                step(1'b1, data_t'($urandom), 1'b0, 1'b0);
                checks++;
                if (observed() !== expected()) begin
                    errors++;
                    $display("FAIL wrap round %0d write %0d: got %h expected %h",
                             r, i, observed(), expected());
                end
            end
            for (int i = 0; i < 12; i++) begin
                step(1'b0, '0, 1'b1, 1'b0);
                checks++;
                if (observed() !== expected()) begin
                    errors++;
                    $display("FAIL wrap round %0d read %0d: got %h expected %h",
                             r, i, observed(), expected());
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        int targets[3] = '{0, 5, 16};
        for (int t = 0; t < 3; t++) begin
            while (q.size() < targets[t]) step(1'b1, data_t'($urandom), 1'b0, 1'b0);
            step(1'b1, data_t'($urandom), 1'b1, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL simultaneous at count %0d: got %h expected %h",
                         targets[t], observed(), expected());
            end
            step(1'b0, '0, 1'b0, 1'b1);
        end
        while (q.size() > 0) begin
            step(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL simultaneous drain: got %h expected %h", observed(), expected());
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) step(1'b1, data_t'(8'h30 + i), 1'b0, 1'b0);
        step(1'b1, 8'h40, 1'b1, 1'b0);
        #2;
        clkrstn.rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (observed() !== expected()) begin
            errors++;
            $display("FAIL async_reset_mid_burst: got %h expected %h", observed(), expected());
        end
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clkrstn.clk);
        clkrstn.rst = 1'b0;
        step(1'b1, 8'h5C, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (observed() !== expected()) begin
            errors++;
            $display("FAIL post_reset_5C: got %h expected %h", observed(), expected());
        end
    endtask

    task automatic test_random();
        int pw, pr;
        for (int i = 0; i < 400; i++) begin
            pw = (i < 200) ? 70 : 30;
            pr = (i < 200) ? 30 : 70;
            step($urandom_range(0, 99) < pw, data_t'($urandom),
                 $urandom_range(0, 99) < pr, $urandom_range(0, 7) == 0);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL random step %0d: got %h expected %h", i, observed(), expected());
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_underflow();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
